// File: rtl/regfile_op_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_op_sequencer
//
// Multi-cycle controller between the instruction decoder and a 16-word memory
// bank. Accepts one register-level operation at a time, reads its operands
// through the bank's single address port, runs a 16-bit ALU op, writes the
// result back and pulses done (plus err for an illegal opcode).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   instr_valid/ready       upstream handshake; ready only while idle
//   instr_op/dst/a/b/imm    operation fields, latched on accept
//   mem_addr/data/we        memory bank port; we high only during write-back
//   mem_q                   bank read data for the address of the previous clk
//   done, err               one-cycle completion pulse, illegal-op pulse
//   result, flag_z, flag_c  last computed value and flags, held
//   retired                 completed-operation count (wraps)
//
// States:
//   state  | meaning
//   IDLE   | waiting for an operation, instr_ready=1
//   RD_A   | address operand A
//   RD_B   | address operand B, capture A from mem_q
//   EXEC   | compute from captured A and mem_q, latch result/flags
//   WB     | write result to dst (mem_we=1)
//   DONE   | done pulse, count the operation
// -----------------------------------------------------------------------------
module regfile_op_sequencer #(
    parameter int DW   = 16,
    parameter int AW   = 4,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [2:0]      instr_op,
    input  logic [AW-1:0]   instr_dst,
    input  logic [AW-1:0]   instr_a,
    input  logic [AW-1:0]   instr_b,
    input  logic [DW-1:0]   instr_imm,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_data,
    output logic            mem_we,
    input  logic [DW-1:0]   mem_q,
    output logic            done,
    output logic [DW-1:0]   result,
    output logic            flag_z,
    output logic            flag_c,
    output logic            err,
    output logic [CNTW-1:0] retired
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_RD_B = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MOV  = 3'b100;
    localparam logic [2:0] OP_CLR  = 3'b101;
    localparam logic [2:0] OP_OUT  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    logic [2:0]      r_state;
    logic [2:0]      r_op;
    logic [AW-1:0]   r_dst;
    logic [AW-1:0]   r_a;
    logic [AW-1:0]   r_b;
    logic [DW-1:0]   r_opa;
    logic [DW-1:0]   r_result;
    logic            r_flag_z;
    logic            r_flag_c;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_data;
    logic            r_mem_we;
    logic            r_done;
    logic            r_err;
    logic [CNTW-1:0] r_retired;

    logic            w_accept;
    logic [2:0]      w_next_state;
    logic [DW:0]     w_sum;
    logic [DW-1:0]   w_exec_val;
    logic [DW-1:0]   w_wb_val;
    logic [DW-1:0]   w_imm_val;

    assign w_accept = instr_valid && (r_state == S_IDLE);
    assign w_sum    = {1'b0, r_opa} + {1'b0, mem_q};
    assign w_imm_val = (instr_op == OP_LOAD) ? instr_imm : '0;

    always_comb begin
        w_exec_val = mem_q;
        case (r_op)
            OP_ADD:  w_exec_val = w_sum[DW-1:0];
            OP_SUB:  w_exec_val = r_opa - mem_q;
            default: w_exec_val = mem_q;
        endcase
    end

    // WB is entered either straight from IDLE (LOAD/CLR) or from EXEC.
    assign w_wb_val = (r_state == S_IDLE) ? w_imm_val : w_exec_val;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (instr_op)
                        OP_ADD, OP_SUB, OP_MOV, OP_OUT: w_next_state = S_RD_A;
                        OP_LOAD, OP_CLR:                w_next_state = S_WB;
                        default:                        w_next_state = S_DONE;
                    endcase
                end
            end
            S_RD_A:  w_next_state = (r_op == OP_ADD || r_op == OP_SUB) ? S_RD_B : S_EXEC;
            S_RD_B:  w_next_state = S_EXEC;
            S_EXEC:  w_next_state = (r_op == OP_OUT) ? S_DONE : S_WB;
            S_WB:    w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Memory-side outputs and pulses are registered from the next state so
    // they are glitch-free and line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= OP_NOP;
            r_dst      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_opa      <= '0;
            r_result   <= '0;
            r_flag_z   <= 1'b0;
            r_flag_c   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_we   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_state  <= w_next_state;
            r_mem_we <= (w_next_state == S_WB);
            r_done   <= (w_next_state == S_DONE);
            r_err    <= w_accept && (instr_op == OP_ILL);
            r_mem_data <= (w_next_state == S_WB) ? w_wb_val : '0;

            case (w_next_state)
                S_RD_A:  r_mem_addr <= instr_a;
                S_RD_B:  r_mem_addr <= r_b;
                S_WB:    r_mem_addr <= (r_state == S_IDLE) ? instr_dst : r_dst;
                default: r_mem_addr <= r_mem_addr;
            endcase

            if (w_accept) begin
                r_op  <= instr_op;
                r_dst <= instr_dst;
                r_a   <= instr_a;
                r_b   <= instr_b;
                if (instr_op == OP_LOAD || instr_op == OP_CLR) begin
                    r_result <= w_imm_val;
                    r_flag_z <= (w_imm_val == '0);
                end
            end

            if (r_state == S_RD_B) begin
                r_opa <= mem_q;
            end

            if (r_state == S_EXEC) begin
                r_result <= w_exec_val;
                r_flag_z <= (w_exec_val == '0);
                if (r_op == OP_ADD) begin
                    r_flag_c <= w_sum[DW];
                end else if (r_op == OP_SUB) begin
                    r_flag_c <= (r_opa < mem_q);
                end
            end

            if (w_next_state == S_DONE) begin
                r_retired <= r_retired + CNTW'(1);
            end
        end
    end

    assign instr_ready = (r_state == S_IDLE);
    assign mem_addr    = r_mem_addr;
    assign mem_data    = r_mem_data;
    assign mem_we      = r_mem_we;
    assign done        = r_done;
    assign err         = r_err;
    assign result      = r_result;
    assign flag_z      = r_flag_z;
    assign flag_c      = r_flag_c;
    assign retired     = r_retired;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
module tb_regfile_op_sequencer;

    localparam int DW   = 16;
    localparam int AW   = 4;
    localparam int CNTW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            instr_valid;
    logic            instr_ready;
    logic [2:0]      instr_op;
    logic [AW-1:0]   instr_dst;
    logic [AW-1:0]   instr_a;
    logic [AW-1:0]   instr_b;
    logic [DW-1:0]   instr_imm;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data;
    logic            mem_we;
    logic [DW-1:0]   mem_q;
    logic            done;
    logic [DW-1:0]   result;
    logic            flag_z;
    logic            flag_c;
    logic            err;
    logic [CNTW-1:0] retired;

    regfile_op_sequencer #(.DW(DW), .AW(AW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_dst(instr_dst), .instr_a(instr_a),
        .instr_b(instr_b), .instr_imm(instr_imm),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q),
        .done(done), .result(result), .flag_z(flag_z), .flag_c(flag_c),
        .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    // Memory bank: one-clock read latency, write on mem_we.
    logic [DW-1:0] mem [16] = '{default: 16'h0};
    always @(posedge clk) begin
        mem_q <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] result;
        logic        z;
        logic        c;
        logic        err;
        logic [7:0]  ret;
        int          lat;
        int          nwr;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int wr_seen = 0;
    int last_acc = 0;

    // Reference model state
    logic [15:0] ref_mem [16] = '{default: 16'h0};
    logic [15:0] m_result = 16'h0;
    logic        m_z = 1'b0;
    logic        m_c = 1'b0;
    logic [7:0]  m_ret = 8'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL spurious_we: write addr=%0h data=%0h with no op outstanding", mem_addr, mem_data);
            end else begin
                chk("we_allowed", 32'(exp_q[0].nwr), 32'd1);
                chk("wr_addr", 32'(mem_addr), 32'(exp_q[0].waddr));
                chk("wr_data", 32'(mem_data), 32'(exp_q[0].wdata));
                wr_seen++;
            end
        end else begin
            chk("mem_data_idle", 32'(mem_data), 32'd0);
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL spurious_done: done=1 with no op outstanding");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", 32'(result), 32'(e.result));
                chk("flag_z", 32'(flag_z), 32'(e.z));
                chk("flag_c", 32'(flag_c), 32'(e.c));
                chk("err", 32'(err), 32'(e.err));
                chk("retired", 32'(retired), 32'(e.ret));
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                chk("write_count", 32'(wr_seen), 32'(e.nwr));
                wr_seen = 0;
            end
        end else begin
            chk("err_without_done", 32'(err), 32'd0);
        end
    end

    task automatic scramble();
        instr_op  = 3'($urandom);
        instr_dst = 4'($urandom);
        instr_a   = 4'($urandom);
        instr_b   = 4'($urandom);
        instr_imm = 16'($urandom);
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic issue(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] a,
                         input logic [3:0] b, input logic [15:0] imm, input bit hold);
        exp_t e;
        int to;
        logic [15:0] va, vb;
        logic [16:0] s;
        instr_op = op; instr_dst = dst; instr_a = a; instr_b = b; instr_imm = imm;
        instr_valid = 1'b1;
        to = 0;
        while (!instr_ready && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (!instr_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: instr_ready stayed 0 for %0d cycles", to);
            instr_valid = 1'b0;
            return;
        end
        va = ref_mem[a];
        vb = ref_mem[b];
        e.err = 1'b0; e.nwr = 0; e.lat = 0; e.waddr = dst; e.wdata = 16'h0;
        case (op)
            3'b001: begin m_result = imm; e.nwr = 1; e.lat = 1; end
            3'b010: begin s = {1'b0, va} + {1'b0, vb}; m_result = s[15:0]; m_c = s[16]; e.nwr = 1; e.lat = 4; end
            3'b011: begin m_result = va - vb; m_c = (va < vb); e.nwr = 1; e.lat = 4; end
            3'b100: begin m_result = va; e.nwr = 1; e.lat = 3; end
            3'b101: begin m_result = 16'h0; e.nwr = 1; e.lat = 1; end
            3'b110: begin m_result = va; e.lat = 2; end
            3'b111: begin e.err = 1'b1; end
            default: ;
        endcase
        if (op != 3'b000 && op != 3'b111) m_z = (m_result == 16'h0);
        if (e.nwr == 1) begin
            ref_mem[dst] = m_result;
            e.wdata = m_result;
        end
        m_ret = m_ret + 8'd1;
        e.result = m_result; e.z = m_z; e.c = m_c; e.ret = m_ret;
        e.acc = cyc + 1;
        last_acc = e.acc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) begin
            instr_valid = 1'b0;
            scramble();
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int to;
        to = 0;
        while (exp_q.size() > 0 && to < 200) begin
            @(negedge clk);
            to++;
        end
        if (exp_q.size() > 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d ops still outstanding", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"},   32'(instr_ready), 32'd1);
        chk({tag, "_we"},      32'(mem_we), 32'd0);
        chk({tag, "_addr"},    32'(mem_addr), 32'd0);
        chk({tag, "_data"},    32'(mem_data), 32'd0);
        chk({tag, "_done"},    32'(done), 32'd0);
        chk({tag, "_err"},     32'(err), 32'd0);
        chk({tag, "_result"},  32'(result), 32'd0);
        chk({tag, "_z"},       32'(flag_z), 32'd0);
        chk({tag, "_c"},       32'(flag_c), 32'd0);
        chk({tag, "_retired"}, 32'(retired), 32'd0);
    endtask

    initial begin
        int prev;
        instr_valid = 1'b0;
        scramble();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed sequence
        issue(3'b001, 4'd3, 4'd0, 4'd0, 16'h1234, 1'b0);
        issue(3'b001, 4'd1, 4'd0, 4'd0, 16'hFFFF, 1'b0);
        issue(3'b001, 4'd2, 4'd0, 4'd0, 16'h0001, 1'b0);
        issue(3'b010, 4'd4, 4'd1, 4'd2, 16'h0, 1'b0);
        issue(3'b001, 4'd5, 4'd0, 4'd0, 16'h0003, 1'b0);
        issue(3'b001, 4'd6, 4'd0, 4'd0, 16'h0007, 1'b0);
        issue(3'b011, 4'd5, 4'd5, 4'd6, 16'h0, 1'b0);
        issue(3'b110, 4'd0, 4'd5, 4'd0, 16'h0, 1'b0);
        issue(3'b111, 4'd9, 4'd1, 4'd2, 16'hBEEF, 1'b0);
        issue(3'b000, 4'd9, 4'd1, 4'd2, 16'hBEEF, 1'b0);
        issue(3'b100, 4'd8, 4'd5, 4'd0, 16'h0, 1'b0);
        issue(3'b101, 4'd6, 4'd0, 4'd0, 16'hAAAA, 1'b0);
        issue(3'b001, 4'd7, 4'd0, 4'd0, 16'h5A5A, 1'b0);
        issue(3'b010, 4'd1, 4'd1, 4'd1, 16'h0, 1'b0);
        issue(3'b011, 4'd2, 4'd2, 4'd2, 16'h0, 1'b0);
        drain();

        // Reset in the middle of an ADD (in EXEC): no write, no done.
        instr_op = 3'b010; instr_dst = 4'd7; instr_a = 4'd3; instr_b = 4'd4;
        instr_valid = 1'b1;
        chk("pre_abort_ready", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_result = 16'h0; m_z = 1'b0; m_c = 1'b0; m_ret = 8'h0;
        wr_seen = 0;
        repeat (8) @(negedge clk);
        chk("post_abort_ready", 32'(instr_ready), 32'd1);

        // 256 back-to-back NOPs with instr_valid held high; retired wraps to 0.
        for (int i = 0; i < 256; i++) begin
            prev = last_acc;
            issue(3'b000, 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom), 1'b1);
            if (i > 0) chk("b2b_spacing", 32'(last_acc - prev), 32'd2);
        end
        instr_valid = 1'b0;
        drain();
        chk("wrapped_retired", 32'(retired), 32'd0);

        // dst of the aborted ADD must still hold its old value.
        issue(3'b110, 4'd0, 4'd7, 4'd0, 16'h0, 1'b0);

        // Randomized operations
        for (int i = 0; i < 80; i++) begin
            logic [15:0] imm;
            imm = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            issue(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom), imm, 1'b0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Multi-cycle controller that takes one register-level operation at a time and drives the 16x16 memory bank through its single address, write-data and write-enable port.
- Reads operands, performs a 16-bit ALU op, writes the result back and reports completion and flags.
- Sits between the Mini-CPU instruction decoder (upstream, valid/ready) and the memory bank (downstream). The memory bank's read data follows its address by one clock.

Parameters:
- DW, 16, data width (memory word width)
- AW, 4, memory address width (16 words)
- CNTW, 8, width of retired-operation counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  operation presented
- instr_ready  out  1  sequencer can accept
- instr_op  in  3  000 NOP, 001 LOAD, 010 ADD, 011 SUB, 100 MOV, 101 CLR, 110 OUT, 111 illegal
- instr_dst  in  AW  destination word
- instr_a  in  AW  operand A address
- instr_b  in  AW  operand B address
- instr_imm  in  DW  immediate (LOAD only)
- mem_addr  out  AW  memory address
- mem_data  out  DW  memory write data
- mem_we  out  1  memory write enable
- mem_q  in  DW  memory read data (for the address presented on the previous clk)
- done  out  1  one-cycle completion pulse
- result  out  DW  last computed value, held
- flag_z  out  1  result==0, held
- flag_c  out  1  ADD carry-out / SUB borrow, held
- err  out  1  one-cycle pulse together with done for illegal op
- retired  out  CNTW  completed-operation count

Behaviour:
- Reset (async, rst_n=0): state IDLE; instr_ready=1; mem_we=0; mem_addr=0; mem_data=0; done=0; err=0; result=0; flag_z=0; flag_c=0; retired=0; latched fields=0. Reset mid-operation aborts it with no write and no done pulse.
- States: IDLE, RD_A, RD_B, EXEC, WB, DONE.
- instr_ready=1 only in IDLE.
- Accept: an operation is accepted at the edge where instr_valid&&instr_ready. op, dst, a, b and imm are latched at that edge. Inputs are don't-care afterwards.
- IDLE transitions on accept:
  - ADD, SUB, MOV, OUT go to RD_A.
  - LOAD and CLR go to WB, with result=imm or 0 latched at accept.
  - NOP and illegal go to DONE.
- RD_A: mem_addr=a. ADD/SUB go to RD_B. MOV/OUT go to EXEC.
- RD_B: mem_addr=b; opA<=mem_q; next EXEC.
- EXEC:
  - ADD/SUB: opB=mem_q. ADD computes {c,sum}=opA+opB. SUB computes opA-opB, with c=1 iff opA<opB (unsigned borrow).
  - MOV/OUT: result=mem_q; c unchanged.
  - Latch result and flag_z at the EXEC edge.
  - OUT goes to DONE; all others go to WB.
- WB: mem_addr=dst, mem_data=result, mem_we=1 for exactly this cycle; next DONE.
  - LOAD/CLR update result and flag_z here (flag_c unchanged).
- DONE: done=1; err=1 iff illegal op; retired increments, wrapping 2^CNTW-1 -> 0. NOP and illegal increment it too. Next IDLE.
- mem_we=0 in every state except WB.
- mem_addr holds its last value in IDLE/DONE. mem_data=0 outside WB.
- Latency: accept edge N -> done high in the cycle after edge N+k:
  - k=4 for ADD/SUB
  - k=3 for MOV
  - k=2 for OUT
  - k=1 for LOAD/CLR
  - k=0 for NOP/illegal
  - The next accept is possible at edge N+k+2.
- dst may equal a or b. Operands are read before WB, so the old value is used.
- result and flags hold until the next operation updates them. NOP and illegal leave them unchanged.
- 16-bit arithmetic wraps modulo 2^16.

Test Plan:
- Reset mid-ADD (assert rst_n=0 in EXEC) -> no mem_we pulse, no done, all outputs at reset values, instr_ready=1 after release.
- LOAD dst=3 imm=0x1234 -> mem_we=1 one cycle with mem_addr=3, mem_data=0x1234; done 1 cycle after accept edge; result=0x1234; flag_z=0.
- With mem[1]=0xFFFF, mem[2]=0x0001, ADD dst=4 a=1 b=2 -> write 0x0000 to addr 4; flag_z=1, flag_c=1; done 4 cycles after accept edge; retired +1.
- With mem[5]=3, mem[6]=7, SUB dst=5 a=5 b=6 -> writes 0xFFFC to 5; flag_c=1 (borrow); flag_z=0. A following OUT a=5 gives result=0xFFFC with no mem_we.
- Illegal op 111 then NOP -> each produces done with no mem_we; err=1 only for the illegal op; result and flags unchanged; retired +2.
- Back-to-back: instr_valid held high with 256 NOPs -> instr_ready pulses every 2 cycles; retired wraps to 0.
